bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-core memory bus arbiter: data requests beat instruction requests,
// ties inside a class are broken by a round-robin pointer, and one word is
// moved per grant with a single IDLE bubble between grants.
// Build option: define ARB_FIXED_PRIORITY_EN to make core 0 win every tie
// (the round-robin pointer is then held at 0).

package cpu_types_pkg;
   typedef logic [31:0] word_t;
endpackage

module bus_arbiter
   import cpu_types_pkg::*;
(
   input  logic          CLK,
   input  logic          nRST,
   input  logic [1:0]    iREN,
   input  logic [1:0]    dREN,
   input  logic [1:0]    dWEN,
   input  word_t [1:0]   iaddr,
   input  word_t [1:0]   daddr,
   input  word_t [1:0]   dstore,
   input  logic          mem_ready,
   input  word_t         ramload,
   output logic          ramREN,
   output logic          ramWEN,
   output word_t         ramaddr,
   output word_t         ramstore,
   output logic [1:0]    iwait,
   output logic [1:0]    dwait,
   output word_t [1:0]   iload,
   output word_t [1:0]   dload,
   output logic          gnt_valid,
   output logic          gnt_core
);

   // state  | meaning
   // IDLE   | no grant; arbitrate requests sampled this cycle
   // DGRANT | data access of core 'owner' in progress
   // IGRANT | instruction fetch of core 'owner' in progress
   typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

   state_t     state;
   logic       owner;
   logic       rr;
   logic [1:0] dreq;
   logic       owner_live;

   assign dreq = dREN | dWEN;

   // Sole requester wins; with two requesters the pointer decides.
   function automatic logic pick(input logic [1:0] req, input logic ptr);
      if (req == 2'b11) return ptr;
      return req[1];
   endfunction

   // Owner still asserting the request class it was granted for.
   always_comb begin
      owner_live = 1'b0;
      case (state)
         DGRANT:  owner_live = dreq[owner];
         IGRANT:  owner_live = iREN[owner];
         default: owner_live = 1'b0;
      endcase
   end

   // Grant sequencing: arbitrate in IDLE, release on completion or abort.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         owner <= 1'b0;
         rr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|dreq) begin
                  state <= DGRANT;
                  owner <= pick(dreq, rr);
               end else if (|iREN) begin
                  state <= IGRANT;
                  owner <= pick(iREN, rr);
               end
            end
            default: begin
               if (!owner_live) begin
                  // abort: pointer untouched so the same core keeps its turn
                  state <= IDLE;
               end else if (mem_ready) begin
                  state <= IDLE;
`ifdef ARB_FIXED_PRIORITY_EN
                  rr    <= 1'b0;
`else
                  rr    <= ~owner;
`endif
               end
            end
         endcase
      end
   end

   // Downstream strobes and per-core waits follow the owner's live inputs.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 2'b11;
      dwait    = 2'b11;
      if (state == DGRANT && owner_live) begin
         ramaddr      = daddr[owner];
         ramstore     = dstore[owner];
         ramWEN       = dWEN[owner];
         ramREN       = ~dWEN[owner];
         dwait[owner] = ~mem_ready;
      end else if (state == IGRANT && owner_live) begin
         ramaddr      = iaddr[owner];
         ramREN       = 1'b1;
         iwait[owner] = ~mem_ready;
      end
   end

   assign gnt_valid = (state != IDLE);
   assign gnt_core  = owner;
   assign iload     = {ramload, ramload};
   assign dload     = {ramload, ramload};

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: reset checks, a scripted vector table, async reset
// mid-grant, and a randomized run against a transaction-level model.

module tb_bus_arbiter;
   import cpu_types_pkg::*;

   logic         CLK;
   logic         nRST;
   logic [1:0]   iREN, dREN, dWEN;
   word_t [1:0]  iaddr, daddr, dstore;
   logic         mem_ready;
   word_t        ramload;
   logic         ramREN, ramWEN;
   word_t        ramaddr, ramstore;
   logic [1:0]   iwait, dwait;
   word_t [1:0]  iload, dload;
   logic         gnt_valid, gnt_core;

   bus_arbiter dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .mem_ready(mem_ready),
      .ramload(ramload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .iwait(iwait), .dwait(dwait), .iload(iload),
      .dload(dload), .gnt_valid(gnt_valid), .gnt_core(gnt_core)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic [1:0]  iwait;
      logic [1:0]  dwait;
      logic        gv;
      logic        gc;
   } outs_t;

   typedef struct packed {
      logic [1:0] dren;
      logic [1:0] dwen;
      logic [1:0] iren;
      logic       mrdy;
      outs_t      exp;
   } vec_t;

   localparam word_t A_I0 = 32'h0000_1000;
   localparam word_t A_I1 = 32'h0000_1004;
   localparam word_t A_D0 = 32'h0000_2000;
   localparam word_t A_D1 = 32'h0000_0100;
   localparam word_t S0   = 32'h1111_1111;
   localparam word_t S1   = 32'hDEAD_BEEF;

   int checks = 0;
   int errors = 0;

   // Model: current transaction (0 none, 1 data, 2 instruction), its core,
   // and which core gets the next tie.
   int m_kind  = 0;
   int m_owner = 0;
   int m_rr    = 0;

   function automatic int choose(input logic [1:0] req);
      if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIORITY_EN
         return 0;
`else
         return m_rr;
`endif
      end
      return req[1] ? 1 : 0;
   endfunction

   function automatic outs_t model_outs();
      outs_t o;
      o       = '0;
      o.iwait = 2'b11;
      o.dwait = 2'b11;
      o.gv    = (m_kind != 0);
      o.gc    = (m_owner == 1);
      if (m_kind == 1 && (dREN[m_owner] || dWEN[m_owner])) begin
         o.addr  = daddr[m_owner];
         o.store = dstore[m_owner];
         if (dWEN[m_owner]) o.wen = 1'b1;
         else               o.ren = 1'b1;
         if (mem_ready) o.dwait[m_owner] = 1'b0;
      end else if (m_kind == 2 && iREN[m_owner]) begin
         o.addr = iaddr[m_owner];
         o.ren  = 1'b1;
         if (mem_ready) o.iwait[m_owner] = 1'b0;
      end
      return o;
   endfunction

   task automatic check_outs(input string tag, input outs_t e);
      checks++;
      if ({ramREN, ramWEN, ramaddr, ramstore} !== {e.ren, e.wen, e.addr, e.store}) begin
         errors++;
         $display("FAIL %s bus: got ren=%0b wen=%0b addr=%h store=%h, expected ren=%0b wen=%0b addr=%h store=%h",
                  tag, ramREN, ramWEN, ramaddr, ramstore, e.ren, e.wen, e.addr, e.store);
      end
      checks++;
      if (iwait !== e.iwait || dwait !== e.dwait) begin
         errors++;
         $display("FAIL %s waits: got iwait=%b dwait=%b, expected iwait=%b dwait=%b",
                  tag, iwait, dwait, e.iwait, e.dwait);
      end
      checks++;
      if (gnt_valid !== e.gv || (e.gv && gnt_core !== e.gc)) begin
         errors++;
         $display("FAIL %s grant: got valid=%0b core=%0b, expected valid=%0b core=%0b",
                  tag, gnt_valid, gnt_core, e.gv, e.gc);
      end
      checks++;
      if (iload !== {ramload, ramload} || dload !== {ramload, ramload}) begin
         errors++;
         $display("FAIL %s loads: got iload=%h dload=%h, expected both words %h",
                  tag, iload, dload, ramload);
      end
   endtask

   // One clock: check at the falling edge (mode 1 model, mode 2 table),
   // advance the model across the rising edge.
   task automatic run_cycle(input int mode, input outs_t texp, input string tag);
      int  nk, no, nr;
      logic live;
      @(negedge CLK);
      if (mode == 1) check_outs(tag, model_outs());
      else if (mode == 2) check_outs(tag, texp);
      nk = m_kind; no = m_owner; nr = m_rr;
      if (m_kind == 0) begin
         if ((dREN | dWEN) != 2'b00) begin
            nk = 1; no = choose(dREN | dWEN);
         end else if (iREN != 2'b00) begin
            nk = 2; no = choose(iREN);
         end
      end else begin
         live = (m_kind == 1) ? (dREN[m_owner] | dWEN[m_owner]) : iREN[m_owner];
         if (!live) begin
            nk = 0;
         end else if (mem_ready) begin
            nk = 0;
`ifndef ARB_FIXED_PRIORITY_EN
            nr = 1 - m_owner;
`endif
         end
      end
      @(posedge CLK);
      #1;
      m_kind = nk; m_owner = no; m_rr = nr;
   endtask

   function automatic vec_t mk(input logic [1:0] dr, input logic [1:0] dw,
                               input logic [1:0] ir, input logic mr,
                               input logic ren, input logic wen,
                               input word_t addr, input word_t store,
                               input logic [1:0] iw, input logic [1:0] dwt,
                               input logic gv, input logic gc);
      vec_t v;
      v.dren = dr; v.dwen = dw; v.iren = ir; v.mrdy = mr;
      v.exp  = {ren, wen, addr, store, iw, dwt, gv, gc};
      return v;
   endfunction

   vec_t  tbl[$];
   outs_t none;

   initial begin
      none = '0;
      nRST = 1'b0;
      iREN = '0; dREN = 2'b11; dWEN = '0;
      iaddr = {A_I1, A_I0}; daddr = {A_D1, A_D0}; dstore = {S1, S0};
      mem_ready = 1'b0; ramload = 32'h5A5A_0001;

      // reset held with both data requests pending
      repeat (2) @(posedge CLK);
      #1;
      check_outs("reset_hold", model_outs());
      nRST = 1'b1;
      run_cycle(1, none, "rst_release_idle");
      checks++;
      if (gnt_valid !== 1'b1 || gnt_core !== 1'b0 || ramREN !== 1'b1) begin
         errors++;
         $display("FAIL rst_release_grant: got valid=%0b core=%0b ren=%0b, expected 1 0 1",
                  gnt_valid, gnt_core, ramREN);
      end
      dREN = 2'b00;
      run_cycle(1, none, "rst_release_abort");

`ifndef ARB_FIXED_PRIORITY_EN
      // rows: dren dwen iren mrdy | ren wen addr store iwait dwait gv gc
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1, 1, 0, A_D0, S0, 2'b11, 2'b10, 1, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1, 1, 0, A_D1, S1, 2'b11, 2'b01, 1, 1));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1, 1, 0, A_D0, S0, 2'b11, 2'b10, 1, 0));
      tbl.push_back(mk(2'b00, 2'b10, 2'b01, 0, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b00, 2'b10, 2'b01, 0, 0, 1, A_D1, S1, 2'b11, 2'b11, 1, 1));
      tbl.push_back(mk(2'b00, 2'b10, 2'b01, 1, 0, 1, A_D1, S1, 2'b11, 2'b01, 1, 1));
      tbl.push_back(mk(2'b00, 2'b00, 2'b01, 1, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b00, 2'b00, 2'b01, 1, 1, 0, A_I0, 0,  2'b10, 2'b11, 1, 0));
      tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b01, 2'b01, 2'b00, 1, 0, 1, A_D0, S0, 2'b11, 2'b10, 1, 0));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0, 1, 0, A_D1, S1, 2'b11, 2'b11, 1, 1));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0, 1, 0, A_D1, S1, 2'b11, 2'b11, 1, 1));
      tbl.push_back(mk(2'b10, 2'b00, 2'b00, 0, 1, 0, A_D1, S1, 2'b11, 2'b11, 1, 1));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0,    0,  2'b11, 2'b11, 1, 1));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1, 1, 0, A_D1, S1, 2'b11, 2'b01, 1, 1));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0,    0,  2'b11, 2'b11, 0, 0));
      foreach (tbl[i]) begin
         dREN = tbl[i].dren; dWEN = tbl[i].dwen; iREN = tbl[i].iren;
         mem_ready = tbl[i].mrdy; ramload = $urandom;
         run_cycle(2, tbl[i].exp, $sformatf("vec%0d", i));
      end
`else
      // fixed priority: core 0 takes every instruction grant
      iREN = 2'b11; dREN = 2'b00; dWEN = 2'b00; mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         run_cycle(1, none, $sformatf("fixed%0d", i));
         checks++;
         if (iwait[1] !== 1'b1 || (gnt_valid && gnt_core !== 1'b0)) begin
            errors++;
            $display("FAIL fixed_prio%0d: got iwait=%b valid=%0b core=%0b, expected iwait[1]=1 core=0",
                     i, iwait, gnt_valid, gnt_core);
         end
      end
      iREN = 2'b00;
      run_cycle(1, none, "fixed_drain");
`endif

      // async reset in the middle of a stalled data grant
      dREN = 2'b01; dWEN = 2'b00; iREN = 2'b00; mem_ready = 1'b0;
      run_cycle(1, none, "mid_rst_arb");
      run_cycle(1, none, "mid_rst_grant");
      #3;
      nRST = 1'b0;
      #1;
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || gnt_valid !== 1'b0 ||
          dwait !== 2'b11 || ramaddr !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got ren=%0b wen=%0b valid=%0b dwait=%b addr=%h, expected 0 0 0 11 0",
                  ramREN, ramWEN, gnt_valid, dwait, ramaddr);
      end
      m_kind = 0; m_owner = 0; m_rr = 0;
      @(posedge CLK);
      #1;
      dREN = 2'b11;
      nRST = 1'b1;
      run_cycle(1, none, "post_rst_arb");
      run_cycle(1, none, "post_rst_grant");

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         dREN = 2'($urandom);
         dWEN = 2'($urandom) & 2'($urandom);
         iREN = 2'($urandom);
         mem_ready = 1'($urandom);
         ramload = $urandom;
         if ((i % 7) == 0) begin
            iaddr  = {$urandom, $urandom};
            daddr  = {$urandom, $urandom};
            dstore = {$urandom, $urandom};
         end
         run_cycle(1, none, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
